// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the MIPS load/store port. It handles byte, half and word
// accesses to a word RAM, and to a small I/O window (output registers, input port, cycle counter).
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_0000,
  parameter int unsigned NUM_IO_REGS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic [NUM_IO_REGS*32-1:0] io_out,
  input  logic [31:0]              io_in
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t       state_q;
  logic [3:0]   wait_cnt_q;
  logic         resp_valid_q;
  logic [31:0]  addr_q;
  logic [1:0]   size_q;
  logic         write_q;
  logic         uns_q;
  logic [31:0]  wdata_q;
  logic [31:0]  cyc_cnt_q;
  logic [31:0]  mem [DEPTH_WORDS];
  logic [31:0]  io_regs_q [NUM_IO_REGS];

  logic [13:0]   io_off;
  logic [AW-1:0] ram_idx;
  logic          in_ram;
  logic          in_io;
  logic          misaligned;
  logic          io_sel_reg;
  logic          io_sel_in;
  logic          io_sel_cnt;
  logic          acc_err;
  logic [31:0]   rd_word;
  logic          commit;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   store_be = 4'b0001 << lane;
      2'b01:   store_be = lane[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   store_lanes = {4{wd[7:0]}};
      2'b01:   store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          size_q  <= req_size;
          write_q <= req_write;
          uns_q   <= req_unsigned;
          wdata_q <= req_wdata;
          if (WAIT_STATES != 0) begin
            state_q    <= WAIT;
            wait_cnt_q <= 4'(WAIT_STATES - 1);
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end
        end
        WAIT: if (wait_cnt_q == 4'd0) begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end else begin
          wait_cnt_q <= wait_cnt_q - 4'd1;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Decode of the latched request; RAM takes priority should the windows ever overlap.
  always_comb begin
    io_off     = addr_q[15:2];
    ram_idx    = addr_q[AW+1:2];
    in_ram     = {1'b0, addr_q} < RAM_BYTES;
    in_io      = addr_q[31:16] == IO_BASE[31:16];
    misaligned = ((size_q == 2'b01) && addr_q[0]) || ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
    io_sel_reg = io_off < 14'(NUM_IO_REGS);
    io_sel_in  = io_off == 14'(NUM_IO_REGS);
    io_sel_cnt = io_off == 14'(NUM_IO_REGS + 1);
    acc_err    = (size_q == 2'b11) || misaligned ||
                 !(in_ram || (in_io && (size_q == 2'b10) && (io_sel_reg || io_sel_in || io_sel_cnt)));
  end

  always_comb begin
    rd_word = '0;
    if (in_ram) begin
      rd_word = mem[ram_idx];
    end else if (io_sel_cnt) begin
      rd_word = cyc_cnt_q;
    end else if (io_sel_in) begin
      rd_word = io_in;
    end else begin
      for (int k = 0; k < int'(NUM_IO_REGS); k++) begin
        if (io_off == 14'(k)) rd_word = io_regs_q[k];
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_valid_q && acc_err;
  assign resp_rdata = (resp_valid_q && !acc_err && !write_q) ?
                      load_extend(rd_word, size_q, addr_q[1:0], uns_q) : 32'h0;

  // Stores land on the edge that closes the RESP cycle; a reset on that edge wins.
  assign commit = (state_q == RESP) && !reset && write_q && !acc_err;

  always_ff @(posedge clk) begin
    if (commit && in_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (store_be(size_q, addr_q[1:0])[i]) begin
          mem[ram_idx][8*i +: 8] <= store_lanes(size_q, wdata_q)[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_IO_REGS); k++) io_regs_q[k] <= '0;
    end else if (commit && !in_ram) begin
      for (int k = 0; k < int'(NUM_IO_REGS); k++) begin
        if (io_off == 14'(k)) io_regs_q[k] <= wdata_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cyc_cnt_q <= '0;
    else       cyc_cnt_q <= cyc_cnt_q + 32'd1;
  end

  for (genvar k = 0; k < int'(NUM_IO_REGS); k++) begin : g_io_out
    assign io_out[k*32 +: 32] = io_regs_q[k];
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: one instance with one wait state, one with none.
// Issued requests push their expected response; monitors pop and compare on resp_valid.
module tb_data_mem_ctrl;

  localparam logic [31:0] IOB = 32'hFFFF_0000;
  localparam logic [1:0]  SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         v1, v0;
  logic         req_write, req_unsigned;
  logic [1:0]   req_size;
  logic [31:0]  req_addr, req_wdata, io_in;
  logic         rdy1, rdy0, rv1, rv0, er1, er0;
  logic [31:0]  rd1, rd0;
  logic [127:0] io1, io0;

  exp_t q1[$];
  exp_t q0[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_resp1 = 0;
  int   tb_cyc = 0;
  int   rel = 0;
  int   snap;

  data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(1), .IO_BASE(IOB), .NUM_IO_REGS(4)) dut1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1), .io_out(io1), .io_in(io_in));

  data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(0), .IO_BASE(IOB), .NUM_IO_REGS(4)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0), .io_out(io0), .io_in(io_in));

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Response cycle (in negedge-sampled tb_cyc) is acceptance edge + WAIT_STATES.
  task automatic issue(input bit which, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input bit exp_err, input bit expect_resp, input bit is_cnt);
    int   guard = 0;
    exp_t e;
    @(negedge clk);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    if (which) v1 = 1'b1; else v0 = 1'b1;
    while (((which ? rdy1 : rdy0) !== 1'b1) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      chk("accept_timeout", 32'd1, 32'd0);
      v1 = 1'b0; v0 = 1'b0;
      return;
    end
    if (expect_resp) begin
      e.cyc   = tb_cyc + 1 + (which ? 1 : 0);
      e.rdata = is_cnt ? 32'(e.cyc - rel) : exp_rd;
      e.err   = exp_err;
      if (which) q1.push_back(e); else q0.push_back(e);
    end
    @(posedge clk);
    #1;
    v1 = 1'b0; v0 = 1'b0;
  endtask

  task automatic ld(input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                    input logic [31:0] exp_rd, input bit exp_err);
    issue(1'b1, 1'b0, sz, uns, addr, 32'h0, exp_rd, exp_err, 1'b1, 1'b0);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                    input bit exp_err);
    issue(1'b1, 1'b1, sz, 1'b0, addr, wd, 32'h0, exp_err, 1'b1, 1'b0);
  endtask

  task automatic drain();
    int g = 0;
    while ((q1.size() != 0 || q0.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
  endtask

  initial begin : mon1
    exp_t e;
    forever begin
      @(negedge clk);
      if (rv1 === 1'b1) begin
        n_resp1++;
        if (q1.size() == 0) chk("unexpected_resp1", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("rdata1", rd1, e.rdata);
          chk("err1", 32'(er1), 32'(e.err));
          chk("latency1", 32'(tb_cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin : mon0
    exp_t e;
    forever begin
      @(negedge clk);
      if (rv0 === 1'b1) begin
        if (q0.size() == 0) chk("unexpected_resp0", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("rdata0", rd0, e.rdata);
          chk("err0", 32'(er0), 32'(e.err));
          chk("latency0", 32'(tb_cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin : main
    reset = 1'b1; v1 = 1'b0; v0 = 1'b0;
    req_write = 1'b0; req_size = SW; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    io_in = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy1), 32'd0);
    chk("rst_valid", 32'(rv1), 32'd0);
    chk("rst_io_out", io1[31:0] | io1[63:32] | io1[95:64] | io1[127:96], 32'd0);
    reset = 1'b0;
    rel = tb_cyc;
    #1;
    chk("post_rst_ready1", 32'(rdy1), 32'd1);
    chk("post_rst_ready0", 32'(rdy0), 32'd1);
    chk("post_rst_rdata", rd1, 32'd0);
    chk("post_rst_err", 32'(er1), 32'd0);

    // Sub-word loads with extension
    st(SW, 32'h10, 32'hA1B2_C3D4, 1'b0);
    ld(SB, 1'b0, 32'h13, 32'hFFFF_FFA1, 1'b0);
    ld(SB, 1'b1, 32'h13, 32'h0000_00A1, 1'b0);
    ld(SH, 1'b0, 32'h12, 32'hFFFF_A1B2, 1'b0);
    ld(SH, 1'b1, 32'h10, 32'h0000_C3D4, 1'b0);

    // Byte enables on sub-word stores
    st(SB, 32'h11, 32'h1234_565A, 1'b0);
    ld(SW, 1'b0, 32'h10, 32'hA1B2_5AD4, 1'b0);
    st(SH, 32'h12, 32'hABCD_7788, 1'b0);
    ld(SW, 1'b0, 32'h10, 32'h7788_5AD4, 1'b0);

    // Errors: misalignment, out of range, illegal size
    ld(SW, 1'b0, 32'h12, 32'h0, 1'b1);
    st(SW, 32'h20, 32'h1122_3344, 1'b0);
    st(SH, 32'h21, 32'h0000_BEEF, 1'b1);
    st(SX, 32'h20, 32'hFFFF_FFFF, 1'b1);
    ld(SW, 1'b0, 32'h20, 32'h1122_3344, 1'b0);
    st(SW, 32'h3FC, 32'hCAFE_F00D, 1'b0);
    ld(SW, 1'b0, 32'h3FC, 32'hCAFE_F00D, 1'b0);
    ld(SB, 1'b0, 32'h3FF, 32'hFFFF_FFCA, 1'b0);
    ld(SH, 1'b0, 32'h3FC, 32'hFFFF_F00D, 1'b0);
    ld(SH, 1'b1, 32'h3FE, 32'h0000_CAFE, 1'b0);
    ld(SW, 1'b0, 32'h400, 32'h0, 1'b1);
    st(SW, 32'h400, 32'h5555_5555, 1'b1);
    ld(SX, 1'b0, 32'h10, 32'h0, 1'b1);
    ld(SW, 1'b0, 32'h8000_0000, 32'h0, 1'b1);

    // I/O window
    st(SW, IOB + 32'h4, 32'h0000_DEAD, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("io_out_in_resp", io1[63:32], 32'h0);
    @(negedge clk);
    chk("io_out_after_resp", io1[63:32], 32'h0000_DEAD);
    chk("io_out_reg0", io1[31:0], 32'h0);
    ld(SW, 1'b0, IOB + 32'h4, 32'h0000_DEAD, 1'b0);
    ld(SW, 1'b0, IOB + 32'h10, 32'h1234_5678, 1'b0);
    st(SW, IOB + 32'h10, 32'h0000_0005, 1'b0);
    ld(SW, 1'b0, IOB + 32'h18, 32'h0, 1'b1);
    st(SB, IOB, 32'h0000_0011, 1'b1);
    ld(SH, 1'b0, IOB + 32'h4, 32'h0, 1'b1);
    issue(1'b1, 1'b0, SW, 1'b0, IOB + 32'h14, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 1'b0, SW, 1'b0, IOB + 32'h14, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Continuous request stream, one wait state: ready 1,0,0
    drain();
    req_write = 1'b0; req_size = SW; req_unsigned = 1'b0; req_addr = 32'h10;
    v1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("ready_pattern1", 32'(rdy1), 32'(i % 3 == 0));
      if (rdy1 === 1'b1) q1.push_back('{32'h7788_5AD4, 1'b0, tb_cyc + 2});
      @(negedge clk);
    end
    v1 = 1'b0;

    // Zero wait states: response next cycle, ready 1,0
    issue(1'b0, 1'b1, SW, 1'b0, 32'h8, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 1'b0, SW, 1'b0, 32'h8, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0);
    drain();
    req_write = 1'b0; req_size = SH; req_unsigned = 1'b0; req_addr = 32'hA;
    v0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ready_pattern0", 32'(rdy0), 32'(i % 2 == 0));
      if (rdy0 === 1'b1) q0.push_back('{32'h0000_0BAD, 1'b0, tb_cyc + 1});
      @(negedge clk);
    end
    v0 = 1'b0;

    // Reset during the wait cycle of a store
    st(SW, 32'h40, 32'h0, 1'b0);
    ld(SW, 1'b0, 32'h40, 32'h0, 1'b0);
    drain();
    snap = n_resp1;
    issue(1'b1, 1'b1, SW, 1'b0, 32'h40, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 32'(rv1), 32'd0);
    chk("rst_mid_ready", 32'(rdy1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rel = tb_cyc;
    #1;
    chk("rst_mid_ready_after", 32'(rdy1), 32'd1);
    chk("rst_mid_io_out", io1[63:32], 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_resp", 32'(n_resp1), 32'(snap));
    ld(SW, 1'b0, 32'h40, 32'h0, 1'b0);
    ld(SW, 1'b0, IOB + 32'h4, 32'h0, 1'b0);
    issue(1'b1, 1'b0, SW, 1'b0, IOB + 32'h14, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

    drain();
    chk("missing_resp1", 32'(q1.size()), 32'd0);
    chk("missing_resp0", 32'(q0.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
